// File: rtl/preg_free_list_pkg.sv
// Shared sizing and tag types for the physical register free list and its neighbours
// (rename, dispatch, retire).
package preg_free_list_pkg;

   localparam int NUM_PREGS = 64;
   localparam int NUM_AREGS = 32;
   localparam int TAG_W     = 6;
   localparam int DEPTH     = NUM_PREGS - NUM_AREGS;
   localparam int PTR_W     = 5;
   localparam int CNT_W     = 6;

   typedef logic [TAG_W-1:0] preg_tag_t;
   typedef logic [PTR_W-1:0] ptr_t;
   typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/preg_free_list_fifo.sv
// free_list_fifo: 2-read/2-write circular buffer of free tags. The caller decides how many
// entries to pop and which pushes are accepted; count alone distinguishes full from empty.
module free_list_fifo
   import preg_free_list_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       pop_cnt,
   input  logic             push_1,
   input  logic [TAG_W-1:0] push_tag_1,
   input  logic             push_2,
   input  logic [TAG_W-1:0] push_tag_2,
   output logic [TAG_W-1:0] head_tag_0,
   output logic [TAG_W-1:0] head_tag_1,
   output logic [CNT_W-1:0] count
);

   preg_tag_t entries [DEPTH];
   ptr_t      head;
   ptr_t      tail;

   assign head_tag_0 = entries[head];
   assign head_tag_1 = entries[head + ptr_t'(1)];

   // A lone slot-2 push lands at tail so accepted pushes stay contiguous.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            entries[i] <= preg_tag_t'(NUM_AREGS + i);
         end
         head  <= '0;
         tail  <= '0;
         count <= cnt_t'(DEPTH);
      end else begin
         if (push_1) begin
            entries[tail] <= push_tag_1;
         end
         if (push_2) begin
            entries[tail + ptr_t'(push_1)] <= push_tag_2;
         end
         head  <= head + ptr_t'(pop_cnt);
         tail  <= tail + ptr_t'(push_1) + ptr_t'(push_2);
         count <= count - cnt_t'(pop_cnt) + cnt_t'(push_1) + cnt_t'(push_2);
      end
   end

endmodule

// File: rtl/preg_free_list.sv
// preg_free_list: all-or-nothing dual-slot tag allocator over free_list_fifo.
// Optional PREG_FREE_LIST_CHECK_EN adds an is_free bitmap and the dbl_free_err output.
module preg_free_list
   import preg_free_list_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             alloc_req_1,
   input  logic             alloc_req_2,
   output logic             alloc_grant,
   output logic [TAG_W-1:0] alloc_tag_1,
   output logic [TAG_W-1:0] alloc_tag_2,
   input  logic             free_flag_1,
   input  logic [TAG_W-1:0] fp_ind_1,
   input  logic             free_flag_2,
   input  logic [TAG_W-1:0] fp_ind_2,
   output logic [TAG_W-1:0] free_count,
`ifdef PREG_FREE_LIST_CHECK_EN
   output logic             dbl_free_err,
`endif
   output logic             overflow_err
);

   logic [1:0]  need;
   logic [1:0]  pop_cnt;
   preg_tag_t   head_tag_0;
   preg_tag_t   head_tag_1;
   cnt_t        count;
   cnt_t        avail;
   logic        ok_1;
   logic        ok_2;
   logic        acc_1;
   logic        acc_2;

   assign need        = {1'b0, alloc_req_1} + {1'b0, alloc_req_2};
   assign alloc_grant = (count >= cnt_t'(need));
   assign pop_cnt     = alloc_grant ? need : 2'd0;
   assign alloc_tag_1 = head_tag_0;
   assign alloc_tag_2 = alloc_req_1 ? head_tag_1 : head_tag_0;
   assign free_count  = count;

   // Room left after this cycle's pops; slot 2 is the first to be dropped.
   assign avail = cnt_t'(DEPTH) - count + cnt_t'(pop_cnt);
   assign acc_1 = ok_1 && (avail != '0);
   assign acc_2 = ok_2 && (avail > cnt_t'(acc_1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow_err <= 1'b0;
      end else if ((ok_1 && !acc_1) || (ok_2 && !acc_2)) begin
         overflow_err <= 1'b1;
      end
   end

`ifdef PREG_FREE_LIST_CHECK_EN
   logic [NUM_PREGS-1:0] is_free;
   logic [NUM_PREGS-1:0] is_free_next;
   logic                 dup_2;
   logic                 dbl_1;
   logic                 dbl_2;

   assign dup_2 = free_flag_1 && free_flag_2 && (fp_ind_1 == fp_ind_2);
   assign dbl_1 = free_flag_1 && is_free[fp_ind_1];
   assign dbl_2 = free_flag_2 && (is_free[fp_ind_2] || dup_2);
   assign ok_1  = free_flag_1 && !dbl_1;
   assign ok_2  = free_flag_2 && !dbl_2;

   always_comb begin
      is_free_next = is_free;
      if (pop_cnt != 2'd0) begin
         is_free_next[head_tag_0] = 1'b0;
      end
      if (pop_cnt == 2'd2) begin
         is_free_next[head_tag_1] = 1'b0;
      end
      if (acc_1) begin
         is_free_next[fp_ind_1] = 1'b1;
      end
      if (acc_2) begin
         is_free_next[fp_ind_2] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         is_free      <= {{DEPTH{1'b1}}, {NUM_AREGS{1'b0}}};
         dbl_free_err <= 1'b0;
      end else begin
         is_free <= is_free_next;
         if (dbl_1 || dbl_2) begin
            dbl_free_err <= 1'b1;
         end
      end
   end

   always @(posedge clk) begin
      if (!rst && pop_cnt != 2'd0) begin
         assert (is_free[head_tag_0])
            else $error("preg_free_list: allocating non-free tag %0d", head_tag_0);
      end
      if (!rst && pop_cnt == 2'd2) begin
         assert (is_free[head_tag_1])
            else $error("preg_free_list: allocating non-free tag %0d", head_tag_1);
      end
   end
`else
   assign ok_1 = free_flag_1;
   assign ok_2 = free_flag_2;
`endif

   free_list_fifo u_fifo (
      .clk        (clk),
      .rst        (rst),
      .pop_cnt    (pop_cnt),
      .push_1     (acc_1),
      .push_tag_1 (fp_ind_1),
      .push_2     (acc_2),
      .push_tag_2 (fp_ind_2),
      .head_tag_0 (head_tag_0),
      .head_tag_1 (head_tag_1),
      .count      (count)
   );

endmodule
